// File: rtl/m65c02_pkg.sv
// Shared encodings for the M65C02 register write-back path and the LST output mux.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package m65c02_pkg;

    // Destination / LST output select codes. Codes 4, 6 and 7 mean "no write".
    typedef enum logic [2:0] {
        WS_NONE = 3'd0,
        WS_X    = 3'd1,
        WS_Y    = 3'd2,
        WS_A    = 3'd3,
        WS_S    = 3'd5
    } wsel_e;

    // Stack-pointer operations. Code 3 is a no-op, just like STK_NONE.
    typedef enum logic [1:0] {
        STK_NONE = 2'd0,
        STK_PUSH = 2'd1,
        STK_PULL = 2'd2,
        STK_NOP  = 2'd3
    } stkop_e;

    localparam logic [7:0] RST_S  = 8'hFF;
    localparam logic [7:0] STK_PG = 8'h01;

    // Apply the prefix overrides to a destination select.
    // OAX and OAY together cancel out. OSY is applied after the A-swap.
    function automatic logic [2:0] remap_wsel(
        input logic [2:0] ws,
        input logic       oax,
        input logic       oay,
        input logic       osy
    );
        logic [2:0] r;
        r = ws;
        if (oax && !oay) begin
            if (ws == WS_A)      r = WS_X;
            else if (ws == WS_X) r = WS_A;
        end else if (oay && !oax) begin
            if (ws == WS_A)      r = WS_Y;
            else if (ws == WS_Y) r = WS_A;
        end
        if (osy) begin
            if (r == WS_Y)      r = WS_S;
            else if (r == WS_S) r = WS_Y;
        end
        return r;
    endfunction

endpackage

// File: rtl/m65c02_sp_unit.sv
// Stack-pointer arithmetic: next SP, stack address and wrap detection for one StkOp.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is committed.
module m65c02_sp_unit
    import m65c02_pkg::*;
#(
    parameter logic [7:0] pStkPg = STK_PG
) (
    input  logic [7:0]  sp_i,
    input  logic [1:0]  stk_op_i,
    output logic [7:0]  sp_nxt_o,
    output logic [15:0] stk_adr_o,
    output logic        adj_o,
    output logic        ovf_o,
    output logic        unf_o
);

    // A push addresses the current SP before the decrement.
    // A pull addresses SP+1, which is also the post-increment SP.
    always_comb begin
        sp_nxt_o  = sp_i;
        stk_adr_o = {pStkPg, sp_i};
        adj_o     = 1'b0;
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        case (stk_op_i)
            STK_PUSH: begin
                sp_nxt_o = sp_i - 8'd1;
                adj_o    = 1'b1;
                ovf_o    = (sp_i == 8'h00);
            end
            STK_PULL: begin
                sp_nxt_o  = sp_i + 8'd1;
                stk_adr_o = {pStkPg, sp_i + 8'd1};
                adj_o     = 1'b1;
                unf_o     = (sp_i == 8'hFF);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m65c02_reg_wb.sv
// A/X/Y/S write-back with prefix-override remap and stack-pointer adjust.
// Optional sticky wrap flags are enabled by M65C02A_STK_CHK_EN.
// Latency: 1 cycle, input to register output; there is no bypass.
// Backpressure: Rdy low freezes all state; StkAdr still follows the inputs.
module m65c02_reg_wb
    import m65c02_pkg::*;
#(
    parameter logic [7:0] pS_Rst = RST_S,
    parameter logic [7:0] pStkPg = STK_PG
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rdy,
    input  logic        Val,
    input  logic [2:0]  WSel,
    input  logic        OAX,
    input  logic        OAY,
    input  logic        OSY,
    input  logic [8:0]  Res,
    input  logic [1:0]  StkOp,
    input  logic        ClrStkErr,
    output logic [7:0]  A,
    output logic [7:0]  X,
    output logic [7:0]  Y,
    output logic [7:0]  S,
    output logic [15:0] StkAdr,
    output logic        WrDone,
    output logic        StkOvf,
    output logic        StkUnf
);

    logic [7:0] a_q, x_q, y_q, s_q;
    logic [7:0] a_d, x_d, y_d, s_d;
    logic       wr_done_q, wr_done_d;

    logic [2:0] dst;
    logic       wr_en;
    logic       sp_hit;
    logic       adj_en;
    logic [7:0] sp;
    logic [7:0] sp_nxt;
    logic       sp_adj;
    logic       sp_ovf;
    logic       sp_unf;

    assign dst = remap_wsel(WSel, OAX, OAY, OSY);
    assign sp  = OSY ? y_q : s_q;

    // Decode a real write and whether it lands on the register currently acting as SP.
    always_comb begin
        wr_en = 1'b0;
        case (dst)
            WS_X, WS_Y, WS_A, WS_S: wr_en = Val;
            default:                wr_en = 1'b0;
        endcase
        sp_hit = wr_en && (OSY ? (dst == WS_Y) : (dst == WS_S));
    end

    m65c02_sp_unit #(
        .pStkPg   (pStkPg)
    ) u_sp_unit (
        .sp_i     (sp),
        .stk_op_i (StkOp),
        .sp_nxt_o (sp_nxt),
        .stk_adr_o(StkAdr),
        .adj_o    (sp_adj),
        .ovf_o    (sp_ovf),
        .unf_o    (sp_unf)
    );

    // A write to the SP register wins over the adjustment (e.g. TXS right after a pull).
    assign adj_en = sp_adj && !sp_hit;

    // Next-state for the register bank: adjustment first, then the write overrides it.
    always_comb begin
        a_d       = a_q;
        x_d       = x_q;
        y_d       = y_q;
        s_d       = s_q;
        wr_done_d = wr_en;
        if (adj_en) begin
            if (OSY) y_d = sp_nxt;
            else     s_d = sp_nxt;
        end
        if (wr_en) begin
            case (dst)
                WS_X:    x_d = Res[7:0];
                WS_Y:    y_d = Res[7:0];
                WS_A:    a_d = Res[7:0];
                WS_S:    s_d = Res[7:0];
                default: ;
            endcase
        end
    end

    // Register bank update, gated by Rdy; reset takes priority over Rdy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q       <= 8'h00;
            x_q       <= 8'h00;
            y_q       <= 8'h00;
            s_q       <= pS_Rst;
            wr_done_q <= 1'b0;
        end else if (Rdy) begin
            a_q       <= a_d;
            x_q       <= x_d;
            y_q       <= y_d;
            s_q       <= s_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign A      = a_q;
    assign X      = x_q;
    assign Y      = y_q;
    assign S      = s_q;
    assign WrDone = wr_done_q;

`ifdef M65C02A_STK_CHK_EN
    logic ovf_q, unf_q;
    logic unused_res;

    assign unused_res = Res[8];

    // Sticky wrap flags; a clear beats a same-cycle set, and a discarded adjust sets nothing.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (Rdy) begin
            if (ClrStkErr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (adj_en && sp_ovf) ovf_q <= 1'b1;
                if (adj_en && sp_unf) unf_q <= 1'b1;
            end
        end
    end

    assign StkOvf = ovf_q;
    assign StkUnf = unf_q;
`else
    logic unused_chk;

    assign unused_chk = ^{Res[8], ClrStkErr, sp_ovf, sp_unf};
    assign StkOvf     = 1'b0;
    assign StkUnf     = 1'b0;
`endif

endmodule

// File: tb/tb_m65c02_reg_wb.sv
// Scoreboard bench for m65c02_reg_wb: expected state is queued at drive time and
// popped after the clock edge; StkAdr is checked combinationally before the edge.
// Build with or without M65C02A_STK_CHK_EN; flag expectations follow the macro.
module tb_m65c02_reg_wb;

`ifdef M65C02A_STK_CHK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic       wd;
        logic       ovf;
        logic       unf;
    } st_t;

    typedef struct {
        logic        rdy;
        logic        val;
        logic [2:0]  wsel;
        logic        oax;
        logic        oay;
        logic        osy;
        logic [8:0]  res;
        logic [1:0]  op;
        logic        clr;
        logic [15:0] adr;
        st_t         exp;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst, Rdy, Val, OAX, OAY, OSY, ClrStkErr;
    logic [2:0]  WSel;
    logic [8:0]  Res;
    logic [1:0]  StkOp;
    logic [7:0]  A, X, Y, S;
    logic [15:0] StkAdr;
    logic        WrDone, StkOvf, StkUnf;

    int   vectors    = 0;
    int   miscompares = 0;
    st_t  sb[$];

    always #5 Clk = ~Clk;

    m65c02_reg_wb dut (
        .Clk(Clk), .Rst(Rst), .Rdy(Rdy), .Val(Val), .WSel(WSel),
        .OAX(OAX), .OAY(OAY), .OSY(OSY), .Res(Res), .StkOp(StkOp),
        .ClrStkErr(ClrStkErr), .A(A), .X(X), .Y(Y), .S(S),
        .StkAdr(StkAdr), .WrDone(WrDone), .StkOvf(StkOvf), .StkUnf(StkUnf)
    );

    function automatic st_t st(input int a, input int x, input int y, input int s,
                               input int wd, input int ovf, input int unf);
        st_t r;
        r.a = a[7:0]; r.x = x[7:0]; r.y = y[7:0]; r.s = s[7:0];
        r.wd = wd[0]; r.ovf = ovf[0]; r.unf = unf[0];
        return r;
    endfunction

    function automatic vec_t mk(input int rdy, input int val, input int ws, input int oax,
                                input int oay, input int osy, input int res, input int op,
                                input int clr, input int adr, input st_t e);
        vec_t v;
        v.rdy = rdy[0]; v.val = val[0]; v.wsel = ws[2:0];
        v.oax = oax[0]; v.oay = oay[0]; v.osy = osy[0];
        v.res = res[8:0]; v.op = op[1:0]; v.clr = clr[0];
        v.adr = adr[15:0]; v.exp = e;
        return v;
    endfunction

    function automatic st_t obs();
        return {A, X, Y, S, WrDone, StkOvf, StkUnf};
    endfunction

    // Drive one cycle from the negedge, sample StkAdr before the edge, queue the expectation.
    task automatic apply(input vec_t v, output logic [15:0] adr);
        Rdy = v.rdy; Val = v.val; WSel = v.wsel;
        OAX = v.oax; OAY = v.oay; OSY = v.osy;
        Res = v.res; StkOp = v.op; ClrStkErr = v.clr;
        #1;
        adr = StkAdr;
        sb.push_back(v.exp);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        st_t got, exp;
        Rst = 1'b1; Rdy = 1'b0; Val = 1'b1; WSel = 3'd3; Res = 9'h1AB;
        OAX = 1'b0; OAY = 1'b0; OSY = 1'b0; StkOp = 2'd1; ClrStkErr = 1'b0;
        sb.push_back(st(8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 0));
        @(posedge Clk);
        @(negedge Clk);
        got = obs(); exp = sb.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset state got %h want %h", got, exp);
        end
        Rst = 1'b0;
    endtask

    task automatic test_write();
        vec_t t[$]; logic [15:0] adr; st_t got, exp;
        t.push_back(mk(1,1,3,0,0,0,9'h05A,0,0,16'h01FF, st(8'h5A,0,0,8'hFF,1,0,0)));
        t.push_back(mk(0,1,3,0,0,0,9'h077,0,0,16'h01FF, st(8'h5A,0,0,8'hFF,1,0,0)));
        t.push_back(mk(1,0,3,0,0,0,9'h099,0,0,16'h01FF, st(8'h5A,0,0,8'hFF,0,0,0)));
        t.push_back(mk(1,1,4,0,0,0,9'h0AA,0,0,16'h01FF, st(8'h5A,0,0,8'hFF,0,0,0)));
        t.push_back(mk(1,1,0,0,0,0,9'h0BB,0,0,16'h01FF, st(8'h5A,0,0,8'hFF,0,0,0)));
        t.push_back(mk(1,1,1,0,0,0,9'h1CC,0,0,16'h01FF, st(8'h5A,8'hCC,0,8'hFF,1,0,0)));
        foreach (t[i]) begin
            apply(t[i], adr);
            vectors++;
            if (adr !== t[i].adr) begin
                miscompares++;
                $display("FAIL write[%0d] StkAdr got %h want %h", i, adr, t[i].adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL write[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_override();
        vec_t t[$]; logic [15:0] adr; st_t got, exp;
        t.push_back(mk(1,1,3,1,0,0,9'h011,0,0,16'h01FF, st(8'h5A,8'h11,0,8'hFF,1,0,0)));
        t.push_back(mk(1,1,1,1,0,0,9'h012,0,0,16'h01FF, st(8'h12,8'h11,0,8'hFF,1,0,0)));
        t.push_back(mk(1,1,2,0,0,1,9'h022,0,0,16'h0100, st(8'h12,8'h11,0,8'h22,1,0,0)));
        t.push_back(mk(1,1,5,0,0,1,9'h023,0,0,16'h0100, st(8'h12,8'h11,8'h23,8'h22,1,0,0)));
        t.push_back(mk(1,1,3,1,1,0,9'h033,0,0,16'h0122, st(8'h33,8'h11,8'h23,8'h22,1,0,0)));
        t.push_back(mk(1,1,3,0,1,0,9'h044,0,0,16'h0122, st(8'h33,8'h11,8'h44,8'h22,1,0,0)));
        t.push_back(mk(1,1,2,0,1,0,9'h045,0,0,16'h0122, st(8'h45,8'h11,8'h44,8'h22,1,0,0)));
        foreach (t[i]) begin
            apply(t[i], adr);
            vectors++;
            if (adr !== t[i].adr) begin
                miscompares++;
                $display("FAIL override[%0d] StkAdr got %h want %h", i, adr, t[i].adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL override[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stack();
        vec_t t[$]; logic [15:0] adr; st_t got, exp;
        t.push_back(mk(1,1,5,0,0,0,9'h000,0,0,16'h0122, st(8'h45,8'h11,8'h44,8'h00,1,0,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,1,0,16'h0100, st(8'h45,8'h11,8'h44,8'hFF,0,CHK,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,0,1,16'h01FF, st(8'h45,8'h11,8'h44,8'hFF,0,0,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,1,0,16'h01FF, st(8'h45,8'h11,8'h44,8'hFE,0,0,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,2,0,16'h01FF, st(8'h45,8'h11,8'h44,8'hFF,0,0,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,3,0,16'h01FF, st(8'h45,8'h11,8'h44,8'hFF,0,0,0)));
        t.push_back(mk(0,0,0,0,0,0,9'h000,1,0,16'h01FF, st(8'h45,8'h11,8'h44,8'hFF,0,0,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,2,0,16'h0100, st(8'h45,8'h11,8'h44,8'h00,0,0,CHK)));
        t.push_back(mk(0,0,0,0,0,0,9'h000,0,1,16'h0100, st(8'h45,8'h11,8'h44,8'h00,0,0,CHK)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,0,1,16'h0100, st(8'h45,8'h11,8'h44,8'h00,0,0,0)));
        foreach (t[i]) begin
            apply(t[i], adr);
            vectors++;
            if (adr !== t[i].adr) begin
                miscompares++;
                $display("FAIL stack[%0d] StkAdr got %h want %h", i, adr, t[i].adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stack[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_osy_pull();
        vec_t t[$]; logic [15:0] adr; st_t got, exp;
        t.push_back(mk(1,1,2,0,0,0,9'h0FF,0,0,16'h0100, st(8'h45,8'h11,8'hFF,8'h00,1,0,0)));
        t.push_back(mk(1,0,0,0,0,1,9'h000,2,0,16'h0100, st(8'h45,8'h11,8'h00,8'h00,0,0,CHK)));
        t.push_back(mk(1,1,2,0,0,0,9'h0FF,0,0,16'h0100, st(8'h45,8'h11,8'hFF,8'h00,1,0,CHK)));
        t.push_back(mk(1,0,0,0,0,1,9'h000,2,1,16'h0100, st(8'h45,8'h11,8'h00,8'h00,0,0,0)));
        t.push_back(mk(1,0,0,0,0,1,9'h000,1,0,16'h0100, st(8'h45,8'h11,8'hFF,8'h00,0,CHK,0)));
        t.push_back(mk(1,0,0,0,0,0,9'h000,0,1,16'h0100, st(8'h45,8'h11,8'hFF,8'h00,0,0,0)));
        foreach (t[i]) begin
            apply(t[i], adr);
            vectors++;
            if (adr !== t[i].adr) begin
                miscompares++;
                $display("FAIL osy_pull[%0d] StkAdr got %h want %h", i, adr, t[i].adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL osy_pull[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_collision();
        vec_t t[$]; logic [15:0] adr; st_t got, exp;
        t.push_back(mk(1,1,5,0,0,0,9'h040,0,0,16'h0100, st(8'h45,8'h11,8'hFF,8'h40,1,0,0)));
        t.push_back(mk(1,1,5,0,0,0,9'h080,2,0,16'h0141, st(8'h45,8'h11,8'hFF,8'h80,1,0,0)));
        t.push_back(mk(1,1,5,0,0,0,9'h0FF,0,0,16'h0180, st(8'h45,8'h11,8'hFF,8'hFF,1,0,0)));
        t.push_back(mk(1,1,5,0,0,0,9'h012,2,0,16'h0100, st(8'h45,8'h11,8'hFF,8'h12,1,0,0)));
        t.push_back(mk(1,1,5,0,0,1,9'h055,1,0,16'h01FF, st(8'h45,8'h11,8'h55,8'h12,1,0,0)));
        t.push_back(mk(1,1,2,0,0,1,9'h066,1,0,16'h0155, st(8'h45,8'h11,8'h54,8'h66,1,0,0)));
        foreach (t[i]) begin
            apply(t[i], adr);
            vectors++;
            if (adr !== t[i].adr) begin
                miscompares++;
                $display("FAIL collision[%0d] StkAdr got %h want %h", i, adr, t[i].adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL collision[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    // Random back-to-back writes with random Rdy stalls against a small reference model.
    task automatic test_back_to_back();
        vec_t v; logic [15:0] adr; st_t got, exp, m;
        int rdy, val, ws, res;
        m = st(8'h45, 8'h11, 8'h54, 8'h66, 1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            val = int'($urandom_range(0, 1));
            ws  = int'($urandom_range(0, 7));
            res = int'($urandom_range(0, 511));
            if (rdy == 1) begin
                m.wd = (val == 1) && (ws == 1 || ws == 2 || ws == 3 || ws == 5);
                if (m.wd) begin
                    if (ws == 1) m.x = res[7:0];
                    if (ws == 2) m.y = res[7:0];
                    if (ws == 3) m.a = res[7:0];
                    if (ws == 5) m.s = res[7:0];
                end
            end
            v = mk(rdy, val, ws, 0, 0, 0, res, 0, 0, {16'h0000, 8'h01, S}, m);
            apply(v, adr);
            vectors++;
            if (adr !== v.adr) begin
                miscompares++;
                $display("FAIL b2b[%0d] StkAdr got %h want %h", i, adr, v.adr);
            end
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b[%0d] AXYS/wd/ovf/unf got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_write();
        test_override();
        test_stack();
        test_osy_pull();
        test_collision();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
